// File: rtl/sensor_conditioner.sv
// sensor_conditioner: two identical, independent loop-detector channels.
// Each channel runs the raw level through a 2-flop synchronizer, debounces
// rises and falls, stretches presence by a hold time, and reports arrivals
// as a one-cycle pulse plus a wrapping 8-bit count.
// Optional build macro SENSOR_STUCK_DETECT_EN adds a per-channel stuck-sensor
// detector: a sensor that stays present for STUCK_CYCLES sets a sticky fault
// and forces the presence output high until reset.

// sensor_channel: one conditioned detector channel.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no vehicle, waiting for a high sync sample        (s=0)
//   ST_QUAL    | counting consecutive high samples toward a rise   (s=0)
//   ST_PRESENT | vehicle present, input high                       (s=1)
//   ST_RELEASE | input low, counting consecutive low samples       (s=1)
//   ST_HOLD    | fall qualified, stretching presence by hold time  (s=1)
module sensor_channel #(
  parameter int DEB_CYCLES   = 8,
  parameter int HOLD_CYCLES  = 16,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_i,
  output logic       s_o,
  output logic       det_o,
  output logic [7:0] cnt_o,
  output logic       fault_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_PRESENT = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] HOLD_V = 8'(HOLD_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] sync_q;
  logic [7:0] tmr_q, tmr_d;
  logic       s_q, s_d;
  logic       det_q, det_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fault_d;
  logic       sync_s;

  assign sync_s = sync_q[1];

`ifdef SENSOR_STUCK_DETECT_EN
  localparam logic [16:0] STUCK_LIM = 17'(STUCK_CYCLES);

  logic [15:0] stk_q, stk_d;
  logic [16:0] stk_nxt;
  logic        fault_q;

  assign stk_nxt = {1'b0, stk_q} + 17'd1;

  // Count consecutive cycles spent in PRESENT; the fault is sticky until reset.
  always_comb begin
    stk_d   = '0;
    fault_d = fault_q;
    if (state_q == ST_PRESENT) begin
      stk_d = stk_q;
      if (!fault_q) begin
        stk_d = stk_nxt[15:0];
        if (stk_nxt >= STUCK_LIM) fault_d = 1'b1;
      end
    end
  end

  // Stuck counter and fault flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stk_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;
`else
  // STUCK_CYCLES has no effect when stuck detection is not built.
  localparam logic STUCK_CFG_OK = (STUCK_CYCLES > 0);

  assign fault_d = 1'b0 & STUCK_CFG_OK;
  assign fault_o = 1'b0;
`endif

  // Next-state and output decode; the low-going debounce counts the
  // PRESENT->RELEASE edge as its first low sample.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    det_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_s) begin
          if (DEB_CYCLES <= 1) begin
            state_d = ST_PRESENT;
            det_d   = 1'b1;
          end else begin
            state_d = ST_QUAL;
            tmr_d   = DEB_M1;
          end
        end
      end
      ST_QUAL: begin
        if (!sync_s) begin
          state_d = ST_IDLE;
        end else if (tmr_q <= 8'd1) begin
          state_d = ST_PRESENT;
          det_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_PRESENT: begin
        if (!sync_s) begin
          if (DEB_CYCLES > 1) begin
            state_d = ST_RELEASE;
            tmr_d   = DEB_M1;
          end else if (HOLD_CYCLES > 0) begin
            state_d = ST_HOLD;
            tmr_d   = HOLD_V;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RELEASE: begin
        if (sync_s) begin
          state_d = ST_PRESENT;
        end else if (tmr_q <= 8'd1) begin
          if (HOLD_CYCLES > 0) begin
            state_d = ST_HOLD;
            tmr_d   = HOLD_V;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (sync_s) begin
          state_d = ST_PRESENT;
        end else if (tmr_q <= 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = cnt_q + {7'd0, det_d};
    s_d   = (state_d == ST_PRESENT) || (state_d == ST_RELEASE) ||
            (state_d == ST_HOLD) || fault_d;
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      s_q     <= 1'b0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      s_q     <= s_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_o   = s_q;
  assign det_o = det_q;
  assign cnt_o = cnt_q;

endmodule

// Top level: road A and road B channels.
module sensor_conditioner #(
  parameter int DEB_CYCLES   = 8,
  parameter int HOLD_CYCLES  = 16,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_a,
  input  logic       raw_b,
  output logic       sa,
  output logic       sb,
  output logic       det_a,
  output logic       det_b,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b,
  output logic       fault_a,
  output logic       fault_b
);

  sensor_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (raw_a),
    .s_o    (sa),
    .det_o  (det_a),
    .cnt_o  (cnt_a),
    .fault_o(fault_a)
  );

  sensor_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (raw_b),
    .s_o    (sb),
    .det_o  (det_b),
    .cnt_o  (cnt_b),
    .fault_o(fault_b)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed latency scenarios plus random
// stimulus, all checked against a run-length reference model.
module tb_sensor_conditioner;

  localparam int DEB   = 8;
  localparam int HOLD  = 16;
  localparam int STUCK = 1024;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] raw;
  logic       sa, sb, det_a, det_b, fault_a, fault_b;
  logic [7:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  sensor_conditioner #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .STUCK_CYCLES(STUCK)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_a  (raw[0]),
    .raw_b  (raw[1]),
    .sa     (sa),
    .sb     (sb),
    .det_a  (det_a),
    .det_b  (det_b),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b),
    .fault_a(fault_a),
    .fault_b(fault_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: presence rises once DEB consecutive high sync samples
  // are seen, falls after DEB+HOLD consecutive low samples. Sync samples are
  // the raw levels delayed by two edges.
  bit         m_d1[2], m_d2[2], m_pres[2], m_det[2], m_fault[2];
  int         m_ones[2], m_zeros[2], m_stk[2];
  logic [7:0] m_cnt[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_d1[c]    <= 1'b0;
        m_d2[c]    <= 1'b0;
        m_pres[c]  <= 1'b0;
        m_det[c]   <= 1'b0;
        m_fault[c] <= 1'b0;
        m_ones[c]  <= 0;
        m_zeros[c] <= 0;
        m_stk[c]   <= 0;
        m_cnt[c]   <= 8'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_d1[c]    <= raw[c];
        m_d2[c]    <= m_d1[c];
        m_ones[c]  <= m_d2[c] ? m_ones[c] + 1 : 0;
        m_zeros[c] <= m_d2[c] ? 0 : m_zeros[c] + 1;
        m_det[c]   <= !m_pres[c] && m_d2[c] && (m_ones[c] + 1 >= DEB);
        if (!m_pres[c] && m_d2[c] && (m_ones[c] + 1 >= DEB)) begin
          m_pres[c] <= 1'b1;
          m_cnt[c]  <= m_cnt[c] + 8'd1;
        end else if (m_pres[c] && !m_d2[c] && (m_zeros[c] + 1 >= DEB + HOLD)) begin
          m_pres[c] <= 1'b0;
        end
`ifdef SENSOR_STUCK_DETECT_EN
        // Steady presence (last sample high) is the state that ages the sensor.
        m_stk[c] <= (m_pres[c] && m_zeros[c] == 0) ? m_stk[c] + 1 : 0;
        if (m_pres[c] && m_zeros[c] == 0 && m_stk[c] + 1 >= STUCK)
          m_fault[c] <= 1'b1;
`endif
      end
    end
  end

  // Every cycle out of reset, compare all outputs with the model.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      chk("sa",      16'(sa),      16'(m_pres[0] | m_fault[0]));
      chk("sb",      16'(sb),      16'(m_pres[1] | m_fault[1]));
      chk("det_a",   16'(det_a),   16'(m_det[0]));
      chk("det_b",   16'(det_b),   16'(m_det[1]));
      chk("cnt_a",   16'(cnt_a),   16'(m_cnt[0]));
      chk("cnt_b",   16'(cnt_b),   16'(m_cnt[1]));
      chk("fault_a", 16'(fault_a), 16'(m_fault[0]));
      chk("fault_b", 16'(fault_b), 16'(m_fault[1]));
    end
  end

  // From a falling edge, pass k rising edges and land on the next falling edge.
  task automatic adv(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sa_low;
    int dets;
    int run[2];

    reset_n = 1'b0;
    raw     = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sa", 16'(sa), 16'd0);
    chk("rst_sb", 16'(sb), 16'd0);
    chk("rst_det_a", 16'(det_a), 16'd0);
    chk("rst_det_b", 16'(det_b), 16'd0);
    chk("rst_cnt_a", 16'(cnt_a), 16'd0);
    chk("rst_cnt_b", 16'(cnt_b), 16'd0);
    chk("rst_fault_a", 16'(fault_a), 16'd0);
    chk("rst_fault_b", 16'(fault_b), 16'd0);

    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Clean rise on A: sa rises exactly DEB+1 edges after the first sample.
    raw[0] = 1'b1;
    adv(DEB + 1);
    chk("rise_early_sa", 16'(sa), 16'd0);
    adv(1);
    chk("rise_sa", 16'(sa), 16'd1);
    chk("rise_det", 16'(det_a), 16'd1);
    chk("rise_cnt", 16'(cnt_a), 16'd1);
    adv(1);
    chk("rise_det_one", 16'(det_a), 16'd0);

    // Short pulse on B never qualifies.
    raw[1] = 1'b1;
    adv(5);
    raw[1] = 1'b0;
    adv(30);
    chk("short_sb", 16'(sb), 16'd0);
    chk("short_cnt_b", 16'(cnt_b), 16'd0);

    // Clean fall on A: sa drops exactly DEB+HOLD+1 edges after the first sample.
    raw[0] = 1'b0;
    adv(DEB + HOLD + 1);
    chk("fall_late_sa", 16'(sa), 16'd1);
    adv(1);
    chk("fall_sa", 16'(sa), 16'd0);
    chk("fall_cnt", 16'(cnt_a), 16'd1);

    // Requalify, then a 3-cycle low glitch must not disturb presence.
    raw[0] = 1'b1;
    adv(DEB + 4);
    chk("req_sa", 16'(sa), 16'd1);
    chk("req_cnt", 16'(cnt_a), 16'd2);
    raw[0] = 1'b0;
    sa_low = 0;
    dets   = 0;
    for (int i = 0; i < 3; i++) begin
      adv(1);
      if (!sa) sa_low++;
      if (det_a) dets++;
    end
    raw[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      adv(1);
      if (!sa) sa_low++;
      if (det_a) dets++;
    end
    chk("glitch_sa_low", 16'(sa_low), 16'd0);
    chk("glitch_det", 16'(dets), 16'd0);
    chk("glitch_cnt", 16'(cnt_a), 16'd2);

    // Fall, then rise again 10 cycles into HOLD: presence stays continuous.
    raw[0] = 1'b0;
    sa_low = 0;
    dets   = 0;
    for (int i = 0; i < DEB + 11; i++) begin
      adv(1);
      if (!sa) sa_low++;
      if (det_a) dets++;
    end
    raw[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      adv(1);
      if (!sa) sa_low++;
      if (det_a) dets++;
    end
    chk("hold_sa_low", 16'(sa_low), 16'd0);
    chk("hold_det", 16'(dets), 16'd0);
    chk("hold_cnt", 16'(cnt_a), 16'd2);

    // 256 arrivals on B while A sits present: cnt_b wraps back to 0.
    for (int i = 0; i < 256; i++) begin
      raw[1] = 1'b1;
      adv(DEB + 2 + int'($urandom_range(0, 4)));
      raw[1] = 1'b0;
      adv(DEB + HOLD + 3 + int'($urandom_range(0, 4)));
      if (i == 254) chk("wrap_cnt_b_255", 16'(cnt_b), 16'd255);
    end
    chk("wrap_cnt_b", 16'(cnt_b), 16'd0);
    chk("wrap_sa", 16'(sa), 16'd1);
    chk("wrap_cnt_a", 16'(cnt_a), 16'd2);
`ifdef SENSOR_STUCK_DETECT_EN
    chk("stuck_fault_a", 16'(fault_a), 16'd1);
    chk("stuck_fault_b", 16'(fault_b), 16'd0);
    raw[0] = 1'b0;
    adv(DEB + HOLD + 10);
    chk("stuck_sa_forced", 16'(sa), 16'd1);
`else
    chk("nostuck_fault_a", 16'(fault_a), 16'd0);
    raw[0] = 1'b0;
    adv(DEB + HOLD + 10);
    chk("nostuck_sa", 16'(sa), 16'd0);
`endif

    // Reset mid-qualification aborts; the still-high input requalifies from scratch.
    raw[0] = 1'b1;
    adv(4);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_sa", 16'(sa), 16'd0);
    chk("midrst_det_a", 16'(det_a), 16'd0);
    chk("midrst_cnt_a", 16'(cnt_a), 16'd0);
    chk("midrst_cnt_b", 16'(cnt_b), 16'd0);
    chk("midrst_fault_a", 16'(fault_a), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    adv(DEB + 1);
    chk("requal_early_sa", 16'(sa), 16'd0);
    adv(1);
    chk("requal_sa", 16'(sa), 16'd1);
    chk("requal_det", 16'(det_a), 16'd1);
    chk("requal_cnt", 16'(cnt_a), 16'd1);

    // Random run lengths on both channels, checked every cycle by the model.
    run[0] = 1;
    run[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          raw[c] = ~raw[c];
          run[c] = int'($urandom_range(1, 40));
        end
      end
      adv(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
